dmem_line_responder: RTL and testbench

- Data-memory side of the cache-to-memory line interface: the responder that a data cache's miss/write-back controller talks to.
- Accepts one 256-bit line read or write per request, models fixed access latency with a counter, and returns a single-cycle acknowledge.
- Holds a line-organised storage array (32-byte lines). It replaces the testbench memory model as synthesizable RTL below the L1 data cache.

---
 rtl/dmem_line_responder_if.sv | 30 +++
 rtl/dmem_line_responder.sv | 133 +++++++++++++
 tb/tb_dmem_line_responder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_line_responder_if.sv
// Cache-to-memory line interface between an L1 data cache miss/write-back
// controller (master) and the data-memory line responder (slave).
//   enable_i : request valid, held by the initiator until ack_o
//   write_i  : 1 = line write, 0 = line read
//   addr_i   : byte address, line index taken from bits above [4:0]
//   data_i   : 256-bit write line
//   ack_o    : one-cycle completion pulse
//   data_o   : 256-bit read line
//   busy_o   : responder is not idle
//   err_o    : address-range error, valid with ack_o
interface dmem_line_responder_if;
    logic         enable_i;
    logic         write_i;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         ack_o;
    logic [255:0] data_o;
    logic         busy_o;
    logic         err_o;

    modport master (
        output enable_i, write_i, addr_i, data_i,
        input  ack_o, data_o, busy_o, err_o
    );

    modport slave (
        input  enable_i, write_i, addr_i, data_i,
        output ack_o, data_o, busy_o, err_o
    );
endinterface

// File: rtl/dmem_line_responder.sv
// Data-memory line responder below the L1 data cache. Accepts one 256-bit
// line read or write per request, completes it LATENCY cycles after
// acceptance with a single-cycle ack, then spends one dead TURN cycle
// before accepting the next request.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset (array contents are kept)
//   bus   : dmem_line_responder_if slave modport (request/response)
// Parameters:
//   ADDR_W  : line-index width, 2**ADDR_W lines of 256 bits
//   LATENCY : acceptance-to-ack cycles, 1..255
// Optional feature macro DMEM_RANGE_CHECK_EN: addresses with nonzero bits
// above the line index complete with err_o=1, leave the array untouched and
// return a zero line on reads. Without it those bits are ignored (aliasing).
module dmem_line_responder #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned LATENCY = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    dmem_line_responder_if.slave  bus
);
    localparam int unsigned LINE_W = 256;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned CNT_W  = 8;
    // Acceptance edge counts as the first latency cycle, so BUSY completes
    // one count earlier; LATENCY==1 completes straight from IDLE.
    localparam logic [CNT_W-1:0] LAST_CNT     = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;
    localparam bit               SINGLE_CYCLE = (LATENCY == 1);

    typedef enum logic [1:0] {IDLE, BUSY, ACK, TURN} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                lat_write_q;
    logic [ADDR_W-1:0]   lat_idx_q;
    logic [LINE_W-1:0]   lat_data_q;
    logic                lat_oor_q;

    logic [LINE_W-1:0]   mem [DEPTH];

    logic [ADDR_W-1:0]   in_idx_c;
    logic                in_oor_c;
    logic                unused_addr_c;

    assign in_idx_c = bus.addr_i[ADDR_W+4:5];

`ifdef DMEM_RANGE_CHECK_EN
    assign in_oor_c      = |bus.addr_i[31:ADDR_W+5];
    assign unused_addr_c = ^bus.addr_i[4:0];
`else
    assign in_oor_c      = 1'b0;
    assign unused_addr_c = ^{bus.addr_i[31:ADDR_W+5], bus.addr_i[4:0]};
`endif

    logic                op_write_c;
    logic [ADDR_W-1:0]   op_idx_c;
    logic [LINE_W-1:0]   op_data_c;
    logic                op_oor_c;
    logic                acc_c;
    logic                mem_we_c;

    // Access operands: live inputs only for a LATENCY==1 completion from IDLE.
    always_comb begin
        op_write_c = lat_write_q;
        op_idx_c   = lat_idx_q;
        op_data_c  = lat_data_q;
        op_oor_c   = lat_oor_q;
        acc_c      = 1'b0;
        if (state_q == IDLE) begin
            op_write_c = bus.write_i;
            op_idx_c   = in_idx_c;
            op_data_c  = bus.data_i;
            op_oor_c   = in_oor_c;
        end
        if (!rst_i) begin
            if (state_q == IDLE)
                acc_c = SINGLE_CYCLE && bus.enable_i;
            else if (state_q == BUSY)
                acc_c = (cnt_q == LAST_CNT);
        end
        mem_we_c = acc_c && op_write_c && !op_oor_c;
    end

    // Line storage, never reset.
    always_ff @(posedge clk_i) begin
        if (mem_we_c)
            mem[op_idx_c] <= op_data_c;
    end

    // Request FSM and registered responses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bus.ack_o   <= 1'b0;
            bus.data_o  <= '0;
            bus.busy_o  <= 1'b0;
            bus.err_o   <= 1'b0;
        end else begin
            bus.ack_o <= 1'b0;
            bus.err_o <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.enable_i) begin
                        lat_write_q <= bus.write_i;
                        lat_idx_q   <= in_idx_c;
                        lat_data_q  <= bus.data_i;
                        lat_oor_q   <= in_oor_c;
                        cnt_q       <= '0;
                        bus.busy_o  <= 1'b1;
                        state_q     <= BUSY;
                    end
                end
                BUSY: cnt_q <= cnt_q + CNT_W'(1);
                ACK:  state_q <= TURN;
                TURN: begin
                    state_q    <= IDLE;
                    bus.busy_o <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
            // Completion overrides the state update above.
            if (acc_c) begin
                bus.ack_o <= 1'b1;
                bus.err_o <= op_oor_c;
                state_q   <= ACK;
                if (!op_write_c)
                    bus.data_o <= op_oor_c ? '0 : mem[op_idx_c];
            end
        end
    end
endmodule

// File: tb/tb_dmem_line_responder.sv
// Randomized self-checking bench for dmem_line_responder. A line-array
// reference model predicts read data, error flags and the exact cycle of
// every ack; directed cases cover latency, write/read, chaining, reset in
// flight and the upper-address case.
module tb_dmem_line_responder;
    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned LATENCY = 10;
    localparam int unsigned LINES   = 1 << ADDR_W;
`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    dmem_line_responder_if bus();

    dmem_line_responder #(
        .ADDR_W  (ADDR_W),
        .LATENCY (LATENCY)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned   n_vec = 0;
    int unsigned   n_bad = 0;
    logic [255:0]  ref_mem [LINES];
    logic [255:0]  ref_data;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned line_of(input logic [31:0] a);
        return (a / 32) % LINES;
    endfunction

    function automatic bit out_of_range(input logic [31:0] a);
        return RANGE_CHK && ((a / 32) >= LINES);
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction. pre = idle cycles before acceptance (1 when called
    // during the previous transaction's TURN cycle). hold = cycles enable
    // stays high after the ack cycle. chain = leave enable high and return
    // in the TURN cycle so the next call can follow immediately.
    task automatic do_txn(input bit wr, input logic [31:0] a, input logic [255:0] d,
                          input int pre, input int hold, input bit chain);
        bit oor;
        int unsigned idx;
        int lat;
        oor = out_of_range(a);
        idx = line_of(a);
        lat = int'(LATENCY);
        bus.enable_i = 1'b1;
        bus.write_i  = wr;
        bus.addr_i   = a;
        bus.data_i   = d;
        for (int j = 1 - pre; j <= lat + 1; j++) begin
            step();
            if (j <= 0) begin
                check_eq("pre_ack", bus.ack_o, 1'b0);
                check_eq("pre_busy", bus.busy_o, 1'b0);
            end else begin
                if (j == lat) begin
                    if (!wr)
                        ref_data = oor ? '0 : ref_mem[idx];
                    else if (!oor)
                        ref_mem[idx] = d;
                end
                check_eq("ack", bus.ack_o, j == lat);
                check_eq("busy", bus.busy_o, 1'b1);
                check_eq("err", bus.err_o, (j == lat) && oor);
                check_eq("data_o", bus.data_o, ref_data);
            end
            // Scramble request fields while busy; the responder must not resample.
            if (j >= 1 && j < lat) begin
                bus.write_i = 1'($urandom);
                bus.addr_i  = $urandom;
                bus.data_i  = rand_line();
            end
            if (!chain && j >= lat && (j - lat) == hold)
                bus.enable_i = 1'b0;
        end
        if (!chain) begin
            for (int k = 0; k < 2; k++) begin
                step();
                check_eq("post_ack", bus.ack_o, 1'b0);
                check_eq("post_busy", bus.busy_o, 1'b0);
                check_eq("post_data", bus.data_o, ref_data);
                if (k == 0) bus.enable_i = 1'b0;
            end
        end
    endtask

    initial begin
        logic [255:0] old5;
        logic [255:0] pat;
        bit pend;
        bit wr;
        bit chain;
        logic [31:0] a;

        rst          = 1'b1;
        bus.enable_i = 1'b0;
        bus.write_i  = 1'b0;
        bus.addr_i   = '0;
        bus.data_i   = '0;
        ref_data     = '0;
        repeat (3) step();
        check_eq("rst_ack", bus.ack_o, 1'b0);
        check_eq("rst_busy", bus.busy_o, 1'b0);
        check_eq("rst_data", bus.data_o, 256'h0);
        check_eq("rst_err", bus.err_o, 1'b0);
        rst = 1'b0;
        step();

        // Preload every line through the bus.
        for (int i = 0; i < int'(LINES); i++)
            do_txn(1'b1, 32'(i * 32), rand_line(), 0, 0, 1'b0);

        // Read latency on line 3.
        do_txn(1'b1, 32'h60, {32{8'hA5}}, 0, 0, 1'b0);
        do_txn(1'b0, 32'h60, '0, 0, 0, 1'b0);
        check_eq("line3", bus.data_o, {32{8'hA5}});

        // Write then read with a non-zero byte offset.
        pat = {4{64'h0123_4567_89AB_CDEF}};
        do_txn(1'b1, 32'hE0, pat, 0, 1, 1'b0);
        do_txn(1'b0, 32'hE4, '0, 0, 0, 1'b0);
        check_eq("line7", bus.data_o, pat);

        // Write-back followed by refill with enable held across the ack.
        do_txn(1'b1, 32'h120, rand_line(), 0, 0, 1'b1);
        do_txn(1'b0, 32'h120, '0, 1, 1, 1'b0);

        // Reset while a write to line 5 is in flight.
        old5         = ref_mem[5];
        bus.enable_i = 1'b1;
        bus.write_i  = 1'b1;
        bus.addr_i   = 32'hA0;
        bus.data_i   = '1;
        for (int j = 1; j <= 5; j++) begin
            step();
            check_eq("rst_mid_ack", bus.ack_o, 1'b0);
            check_eq("rst_mid_busy", bus.busy_o, 1'b1);
        end
        rst          = 1'b1;
        bus.enable_i = 1'b0;
        step();
        ref_data = '0;
        check_eq("rst_mid_busy0", bus.busy_o, 1'b0);
        check_eq("rst_mid_data0", bus.data_o, ref_data);
        rst = 1'b0;
        for (int j = 0; j < 12; j++) begin
            step();
            check_eq("rst_noack", bus.ack_o, 1'b0);
        end
        do_txn(1'b0, 32'hA0, '0, 0, 0, 1'b0);
        check_eq("line5_kept", bus.data_o, old5);

        // Upper address bits set.
        do_txn(1'b0, 32'h0000_4000, '0, 0, 0, 1'b0);

        // Randomized traffic.
        pend = 1'b0;
        for (int i = 0; i < 200; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, LINES - 1) * 32 + $urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0)
                a = a | (32'($urandom_range(1, 255)) << (ADDR_W + 5));
            chain = (i < 199) && ($urandom_range(0, 3) == 0);
            do_txn(wr, a, rand_line(), pend ? 1 : 0, int'($urandom_range(0, 2)), chain);
            pend = chain;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
